mmio_uart: RTL and testbench

- Memory-mapped UART peripheral that acts as the responder for the core's load/store unit accesses.
- Sits beside the data TCM on the MEMPREP-stage access path.
- Accepts stores and loads with the same address/we/width/wdata signalling the data TCM receives.
- Returns read data with the data TCM's fixed 2-cycle latency, so the WB-stage read-data mux needs no handshake.
- Serialises bytes from a TX FIFO onto a pin and deserialises a single-byte RX buffer from a pin.

---
 rtl/mmio_uart_pkg.sv | 24 ++
 rtl/uart_tx_fifo.sv | 49 ++++
 rtl/mmio_uart.sv | 262 ++++++++++++++++++++++++++
 tb/tb_mmio_uart.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, STATUS bit
// positions and the TX/RX state encoding.
package mmio_uart_pkg;

  localparam logic [3:0] OFS_TXDATA  = 4'h0;
  localparam logic [3:0] OFS_RXDATA  = 4'h4;
  localparam logic [3:0] OFS_STATUS  = 4'h8;
  localparam logic [3:0] OFS_BAUDDIV = 4'hC;

  localparam int ST_TX_FULL     = 0;
  localparam int ST_TX_EMPTY    = 1;
  localparam int ST_RX_VALID    = 2;
  localparam int ST_RX_OVERRUN  = 3;
  localparam int ST_TX_BUSY     = 4;
  localparam int ST_TX_OVERFLOW = 5;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  // Word-granular decode: the byte lane bits of the offset are ignored.
  function automatic logic reg_hit(input logic [3:0] a, input logic [3:0] ofs);
    return a[3:2] == ofs[3:2];
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter. A pop in the same cycle as a push
// into a full FIFO frees the slot first, so that push is accepted.
module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               wdata_i,
  output logic [7:0]               rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mmio_uart.sv
// Memory-mapped UART responder on the LSU data path with fixed 2-cycle read
// latency. The receiver is only built when MMIO_UART_RX_EN is defined.
//
// state | meaning (shared by TX and RX FSMs)
// IDLE  | line idle; TX waits for a FIFO byte, RX waits for a falling edge
// START | start bit (RX: half-bit wait then glitch-reject resample)
// DATA  | 8 data bits, LSB first
// STOP  | stop bit; TX chains the next byte without an idle gap
module mmio_uart
  import mmio_uart_pkg::*;
#(
  parameter int TX_FIFO_DEPTH    = 8,
  parameter int DEFAULT_BAUD_DIV = 1215
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  data_width,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  input  logic        rx
);

  localparam int CW = $clog2(TX_FIFO_DEPTH) + 1;

  logic        wr_en, rd_en, push, wr_status, wr_baud;
  logic [15:0] baud_q;
  logic        tx_ovf_q;
  logic [31:0] rd_val, rd_pipe_q, rdata_q;

  logic        fifo_full, fifo_empty, fifo_pop;
  logic [7:0]  fifo_head;
  logic [CW-1:0] fifo_count;

  uart_state_t tx_state_q;
  logic [15:0] tx_cnt_q;
  logic [2:0]  tx_bit_q;
  logic [7:0]  tx_shreg_q;
  logic        tx_q, tx_busy;

  logic        rx_valid_q, rx_ovr_q;
  logic [7:0]  rx_byte_q;

  assign wr_en     = sel && we;
  assign rd_en     = sel && !we;
  assign push      = wr_en && reg_hit(addr, OFS_TXDATA);
  assign wr_status = wr_en && reg_hit(addr, OFS_STATUS);
  assign wr_baud   = wr_en && reg_hit(addr, OFS_BAUDDIV);

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_q   <= 16'(DEFAULT_BAUD_DIV);
      tx_ovf_q <= 1'b0;
    end else begin
      if (wr_baud) baud_q <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
      if (push && fifo_full && !fifo_pop) tx_ovf_q <= 1'b1;
      else if (wr_status && wdata[ST_TX_OVERFLOW]) tx_ovf_q <= 1'b0;
    end
  end

  uart_tx_fifo #(.DEPTH(TX_FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (fifo_pop),
    .wdata_i (wdata[7:0]),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Pop either from IDLE or at the end of STOP so frames run back to back.
  assign fifo_pop = !fifo_empty &&
                    ((tx_state_q == IDLE) || ((tx_state_q == STOP) && (tx_cnt_q == 16'd0)));
  assign tx_busy  = (tx_state_q != IDLE);
  assign tx       = tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= 16'd0;
      tx_bit_q   <= 3'd0;
      tx_shreg_q <= 8'd0;
      tx_q       <= 1'b1;
    end else begin
      unique case (tx_state_q)
        IDLE: begin
          if (fifo_pop) begin
            tx_shreg_q <= fifo_head;
            tx_cnt_q   <= baud_q;
            tx_q       <= 1'b0;
            tx_state_q <= START;
          end
        end
        START: begin
          if (tx_cnt_q == 16'd0) begin
            tx_cnt_q   <= baud_q;
            tx_bit_q   <= 3'd0;
            tx_q       <= tx_shreg_q[0];
            tx_state_q <= DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end
        end
        DATA: begin
          if (tx_cnt_q == 16'd0) begin
            tx_cnt_q <= baud_q;
            if (tx_bit_q == 3'd7) begin
              tx_q       <= 1'b1;
              tx_state_q <= STOP;
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              tx_shreg_q <= {1'b0, tx_shreg_q[7:1]};
              tx_q       <= tx_shreg_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end
        end
        STOP: begin
          if (tx_cnt_q == 16'd0) begin
            if (fifo_pop) begin
              tx_shreg_q <= fifo_head;
              tx_cnt_q   <= baud_q;
              tx_q       <= 1'b0;
              tx_state_q <= START;
            end else begin
              tx_state_q <= IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end
        end
      endcase
    end
  end

`ifdef MMIO_UART_RX_EN
  uart_state_t rx_state_q;
  logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_dlv_q, rd_rx;
  logic [15:0] rx_cnt_q, rx_half_m1;
  logic [16:0] rx_half;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_shreg_q;
  logic        unused_ok;

  assign rd_rx      = rd_en && reg_hit(addr, OFS_RXDATA);
  assign rx_half    = ({1'b0, baud_q} + 17'd1) >> 1;
  assign rx_half_m1 = rx_half[15:0] - 16'd1;
  assign unused_ok  = ^{data_width, addr[1:0], wdata[31:16], fifo_count, rx_half[16]};

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= IDLE;
      rx_cnt_q   <= 16'd0;
      rx_bit_q   <= 3'd0;
      rx_shreg_q <= 8'd0;
      rx_dlv_q   <= 1'b0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_dlv_q  <= 1'b0;
      unique case (rx_state_q)
        IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            rx_cnt_q   <= rx_half_m1;
            rx_state_q <= START;
          end
        end
        START: begin
          if (rx_cnt_q == 16'd0) begin
            rx_cnt_q   <= baud_q;
            rx_bit_q   <= 3'd0;
            rx_state_q <= rx_s2_q ? IDLE : DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end
        end
        DATA: begin
          if (rx_cnt_q == 16'd0) begin
            rx_shreg_q <= {rx_s2_q, rx_shreg_q[7:1]};
            rx_cnt_q   <= baud_q;
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end
        end
        STOP: begin
          // A low stop bit drops the byte; IDLE then needs a fresh high-to-low edge.
          if (rx_cnt_q == 16'd0) begin
            rx_dlv_q   <= rx_s2_q;
            rx_state_q <= IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_byte_q  <= 8'd0;
    end else begin
      if (rd_rx) begin
        rx_valid_q <= 1'b0;
        rx_ovr_q   <= 1'b0;
      end
      if (rx_dlv_q) begin
        if (rx_valid_q && !rd_rx) begin
          rx_ovr_q <= 1'b1;
        end else begin
          rx_valid_q <= 1'b1;
          rx_byte_q  <= rx_shreg_q;
        end
      end
    end
  end
`else
  logic unused_ok;
  assign rx_valid_q = 1'b0;
  assign rx_ovr_q   = 1'b0;
  assign rx_byte_q  = 8'd0;
  assign unused_ok  = ^{data_width, addr[1:0], wdata[31:16], fifo_count, rx};
`endif

  always_comb begin
    rd_val = 32'd0;
    case (addr[3:2])
      OFS_RXDATA[3:2]:  rd_val = {rx_valid_q, 23'd0, rx_byte_q};
      OFS_STATUS[3:2]:  rd_val = {26'd0, tx_ovf_q, tx_busy, rx_ovr_q, rx_valid_q,
                                  fifo_empty, fifo_full};
      OFS_BAUDDIV[3:2]: rd_val = {16'd0, baud_q};
      default:          rd_val = 32'd0;
    endcase
  end

  // Two-stage read pipeline; bubbles carry zero so rdata is 0 when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pipe_q <= 32'd0;
      rdata_q   <= 32'd0;
    end else begin
      rd_pipe_q <= rd_en ? rd_val : 32'd0;
      rdata_q   <= rd_pipe_q;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_mmio_uart.sv
// Scoreboard bench for mmio_uart: reads and TX bytes push expectations into
// queues; independent monitors on rdata and tx pop and compare.
module tb_mmio_uart;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  data_width = 2'b10;
  logic [3:0]  addr = 4'h0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        tx;
  logic        rx = 1'b1;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [7:0]  tx_exp_q[$];
  bit          rd_p1 = 1'b0, rd_p2 = 1'b0;

  bit tx_mon_en = 1'b0;
  int bit_per = 4;
  int frames_done = 0;
  int first_start = 0;
  int last_end = 0;

  mmio_uart #(.TX_FIFO_DEPTH(8), .DEFAULT_BAUD_DIV(1215)) dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .we         (we),
    .data_width (data_width),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .tx         (tx),
    .rx         (rx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Read-side bookkeeping: which cycles should carry read data two cycles later.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      rd_p1 <= 1'b0;
      rd_p2 <= 1'b0;
      exp_q.delete();
      tag_q.delete();
    end else begin
      rd_p1 <= sel && !we;
      rd_p2 <= rd_p1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_p2) begin
        if (exp_q.size() == 0) begin
          chk("rdata_no_expect", 32'd1, 32'd0);
        end else begin
          chk(tag_q.pop_front(), rdata, exp_q.pop_front());
        end
      end else begin
        chk("rdata_idle_zero", rdata, 32'd0);
      end
    end
  end

  initial begin : tx_mon
    logic [9:0] frm;
    logic [7:0] e, got;
    bit has, shape_ok;
    forever begin
      @(negedge clk);
      if (tx_mon_en && !rst && tx === 1'b0) begin
        has = (tx_exp_q.size() != 0);
        e = has ? tx_exp_q.pop_front() : 8'h00;
        frm = {1'b1, e, 1'b0};
        got = 8'h00;
        shape_ok = 1'b1;
        if (frames_done == 0) first_start = cyc;
        for (int b = 0; b < 10; b++) begin
          for (int k = 0; k < bit_per; k++) begin
            if (!(b == 0 && k == 0)) @(negedge clk);
            if (tx !== frm[b]) shape_ok = 1'b0;
            if (k == bit_per / 2 && b >= 1 && b <= 8) got[b-1] = tx;
          end
        end
        last_end = cyc;
        frames_done++;
        chk("tx_frame_expected", 32'(has), 32'd1);
        chk("tx_byte", 32'(got), 32'(e));
        chk("tx_bit_timing", 32'(shape_ok), 32'd1);
      end
    end
  end

  task automatic bus(input logic w, input logic [3:0] a, input logic [31:0] d);
    sel = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus(1'b1, a, d);
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    bus(1'b0, a, 32'd0);
  endtask

  task automatic idle(input int n);
    sel = 1'b0; we = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_frames(input int n, input int limit);
    int t = 0;
    while (frames_done < n && t < limit) begin
      @(posedge clk); #1;
      t++;
    end
    chk("tx_frames_timeout", 32'(t < limit), 32'd1);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (4) begin @(posedge clk); #1; end
    end
    rx = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_rdata", rdata, 32'd0);
    @(posedge clk); #1;

    // Reset register values
    rd(4'h8, 32'h0000_0002, "reset_status");
    idle(3);
    rd(4'hC, 32'd1215, "reset_bauddiv");
    rd(4'h0, 32'd0, "txdata_reads_zero");
    rd(4'h4, 32'd0, "reset_rxdata");
    idle(3);

    // BAUDDIV boundaries: zero stored as one, upper bits dropped
    wr(4'hC, 32'd0);
    rd(4'hC, 32'd1, "bauddiv_zero_is_one");
    wr(4'hD, 32'hFFFF_0003);
    rd(4'hC, 32'd3, "bauddiv_upper_masked");
    idle(3);

    // Single frame 0xA5 at 4 cycles/bit
    bit_per = 4;
    frames_done = 0;
    tx_mon_en = 1'b1;
    tx_exp_q.push_back(8'hA5);
    wr(4'h0, 32'h0000_00A5);
    idle(4);
    rd(4'h8, 32'h0000_0012, "status_busy_in_frame");
    wait_frames(1, 100);
    idle(2);
    rd(4'h8, 32'h0000_0002, "status_idle_after_frame");
    idle(4);

    // FIFO overflow: one byte in flight, then 9 back-to-back pushes
    frames_done = 0;
    tx_exp_q.push_back(8'hFF);
    wr(4'h0, 32'h0000_00FF);
    idle(2);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) tx_exp_q.push_back(8'(i));
      wr(4'h0, 32'(i));
    end
    rd(4'h8, 32'h0000_0031, "status_full_overflow");
    wr(4'h8, 32'h0000_0020);
    rd(4'h8, 32'h0000_0011, "status_overflow_cleared");
    wait_frames(9, 800);
    chk("tx_frame_count", 32'(frames_done), 32'd9);
    chk("tx_frames_contiguous", 32'(last_end - first_start), 32'd359);
    idle(3);
    rd(4'h8, 32'h0000_0002, "status_drained");
    idle(3);
    tx_mon_en = 1'b0;

`ifdef MMIO_UART_RX_EN
    // Framing error is discarded
    rx_frame(8'h55, 1'b0);
    idle(12);
    rd(4'h8, 32'h0000_0002, "rx_framing_discard");
    idle(3);
    rx_frame(8'h3C, 1'b1);
    idle(12);
    rd(4'h8, 32'h0000_0006, "rx_valid_set");
    rd(4'h4, 32'h8000_003C, "rxdata_3c");
    rd(4'h8, 32'h0000_0002, "rx_valid_cleared");
    idle(3);
    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
    idle(12);
    rd(4'h8, 32'h0000_000E, "rx_overrun_set");
    rd(4'h4, 32'h8000_0011, "rxdata_keeps_first");
    rd(4'h8, 32'h0000_0002, "rx_overrun_cleared");
    idle(3);
`else
    rx_frame(8'h3C, 1'b1);
    idle(12);
    rd(4'h4, 32'd0, "rxdata_disabled");
    rd(4'h8, 32'h0000_0002, "status_rx_bits_disabled");
    idle(3);
`endif

    // Reset in the middle of a DATA bit at the default divider
    wr(4'hC, 32'd1215);
    wr(4'h0, 32'h0000_005A);
    idle(1816);
    @(negedge clk);
    chk("tx_mid_data_bit0", 32'(tx), 32'd0);
    @(posedge clk); #1;
    rd(4'h8, 32'h0000_0012, "status_busy_before_reset");
    idle(3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("tx_high_after_reset", 32'(tx), 32'd1);
    @(posedge clk); #1;
    rd(4'h8, 32'h0000_0002, "status_after_reset");
    rd(4'hC, 32'd1215, "bauddiv_after_reset");
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
